walk_phase_controller: RTL and testbench

WALK_PHASE_CONTROLLER -- requirements
Module: walk_phase_controller

---
 rtl/walk_phase_controller.sv | 137 +++++++++++++
 tb/tb_walk_phase_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/walk_phase_controller.sv
// Pedestrian walk-phase sequencer: holds vehicle green until a walk request is
// pending and GREEN_MIN has elapsed, then runs yellow, all-red, walk and flash.
module walk_phase_controller #(
  parameter int GREEN_MIN   = 20,
  parameter int YELLOW_TIME = 6,
  parameter int ALLRED_TIME = 2,
  parameter int WALK_TIME   = 15,
  parameter int FLASH_TIME  = 10,
  parameter int FLASH_HALF  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic walkFlagTv,
  input  logic walkFlagNN,
  input  logic walkFlagNS,
  output logic resetTv,
  output logic resetNN,
  output logic resetNS,
  output logic carGreen,
  output logic carYellow,
  output logic carRed,
  output logic walkTv,
  output logic walkNN,
  output logic walkNS,
  output logic dontWalkTv,
  output logic dontWalkNN,
  output logic dontWalkNS
);

  typedef enum logic [2:0] {
    ST_GREEN,
    ST_YELLOW,
    ST_ALLRED,
    ST_WALK,
    ST_FLASH
  } state_e;

  localparam logic [7:0] GreenLast  = 8'(GREEN_MIN - 1);
  localparam logic [7:0] YellowLast = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] AllredLast = 8'(ALLRED_TIME - 1);
  localparam logic [7:0] WalkLast   = 8'(WALK_TIME - 1);
  localparam logic [7:0] FlashLast  = 8'(FLASH_TIME - 1);
  localparam logic [7:0] HalfLast   = 8'(FLASH_HALF - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] served_q, served_d;
  logic       flash_q, flash_d;
  logic [7:0] half_q, half_d;
  logic [2:0] flags;
  logic       flash_last;

  assign flags = {walkFlagTv, walkFlagNN, walkFlagNS};

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset is synchronous and overrides any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_GREEN;
      timer_q  <= 8'd0;
      served_q <= 3'b000;
      flash_q  <= 1'b1;
      half_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      served_q <= served_d;
      flash_q  <= flash_d;
      half_q   <= half_d;
    end
  end

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    unique case (state_q)
      ST_GREEN:  if (timer_q >= GreenLast && |flags) state_d = ST_YELLOW;
      ST_YELLOW: if (timer_q == YellowLast) state_d = ST_ALLRED;
      ST_ALLRED: begin
        if (timer_q == AllredLast) begin
          state_d  = ST_WALK;
          served_d = flags;
        end
      end
      ST_WALK:   if (timer_q == WalkLast) state_d = ST_FLASH;
      ST_FLASH:  if (timer_q == FlashLast) state_d = ST_GREEN;
      default:   state_d = ST_GREEN;
    endcase

    if (state_d != state_q)   timer_d = 8'd0;
    else if (timer_q == 8'hFF) timer_d = timer_q;
    else                       timer_d = timer_q + 8'd1;
  end

  // Flash phase is primed to 1 outside FLASH so the first flash cycle shows don't-walk.
  always_comb begin
    flash_d = flash_q;
    half_d  = half_q;
    if (state_q != ST_FLASH) begin
      flash_d = 1'b1;
      half_d  = 8'd0;
    end else if (half_q == HalfLast) begin
      flash_d = ~flash_q;
      half_d  = 8'd0;
    end else begin
      half_d  = half_q + 8'd1;
    end
  end

  assign flash_last = (state_q == ST_FLASH) && (timer_q == FlashLast);

  always_comb begin
    carGreen  = 1'b0;
    carYellow = 1'b0;
    carRed    = 1'b0;
    {walkTv, walkNN, walkNS}             = 3'b000;
    {dontWalkTv, dontWalkNN, dontWalkNS} = 3'b111;
    {resetTv, resetNN, resetNS}          = flash_last ? served_q : 3'b000;
    unique case (state_q)
      ST_GREEN:  carGreen  = 1'b1;
      ST_YELLOW: carYellow = 1'b1;
      ST_ALLRED: carRed    = 1'b1;
      ST_WALK: begin
        carRed = 1'b1;
        {walkTv, walkNN, walkNS}             = served_q;
        {dontWalkTv, dontWalkNN, dontWalkNS} = ~served_q;
      end
      ST_FLASH: begin
        carRed = 1'b1;
        {dontWalkTv, dontWalkNN, dontWalkNS} = flash_q ? 3'b111 : ~served_q;
      end
      default:   carGreen  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_walk_phase_controller.sv
// Directed and random stimulus checked every cycle against a phase-offset model
// of the walk-phase sequence.
module tb_walk_phase_controller;

  localparam int GMIN  = 4;
  localparam int Y     = 2;
  localparam int A     = 1;
  localparam int W     = 3;
  localparam int F     = 4;
  localparam int FH    = 1;
  localparam int TOTAL = Y + A + W + F;

  logic clk, reset;
  logic walkFlagTv, walkFlagNN, walkFlagNS;
  logic resetTv, resetNN, resetNS;
  logic carGreen, carYellow, carRed;
  logic walkTv, walkNN, walkNS;
  logic dontWalkTv, dontWalkNN, dontWalkNS;

  walk_phase_controller #(
    .GREEN_MIN(GMIN), .YELLOW_TIME(Y), .ALLRED_TIME(A),
    .WALK_TIME(W), .FLASH_TIME(F), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .reset(reset),
    .walkFlagTv(walkFlagTv), .walkFlagNN(walkFlagNN), .walkFlagNS(walkFlagNS),
    .resetTv(resetTv), .resetNN(resetNN), .resetNS(resetNS),
    .carGreen(carGreen), .carYellow(carYellow), .carRed(carRed),
    .walkTv(walkTv), .walkNN(walkNN), .walkNS(walkNS),
    .dontWalkTv(dontWalkTv), .dontWalkNN(dontWalkNN), .dontWalkNS(dontWalkNS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cycle = 0;

  // Model: either in green (m_g cycles elapsed) or m_k cycles past yellow entry.
  bit       m_green;
  int       m_g, m_k;
  logic [2:0] m_served;
  logic [2:0] flags;
  logic [2:0] pend_clear;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cycle, obs, exp);
    end
  endtask

  task automatic step(input logic rst_in, input logic [2:0] req);
    logic [2:0] e_car, e_walk, e_dw, e_rst;
    int fk;
    @(negedge clk);
    cycle++;
    e_walk = 3'b000;
    e_dw   = 3'b111;
    e_rst  = 3'b000;
    if (m_green)      e_car = 3'b100;
    else if (m_k < Y) e_car = 3'b010;
    else begin
      e_car = 3'b001;
      if (m_k >= Y + A && m_k < Y + A + W) begin
        e_walk = m_served;
        e_dw   = ~m_served;
      end else if (m_k >= Y + A + W) begin
        fk    = m_k - (Y + A + W);
        e_dw  = (((fk / FH) % 2) == 0) ? 3'b111 : ~m_served;
        e_rst = (m_k == TOTAL - 1) ? m_served : 3'b000;
      end
    end
    check("car", {carGreen, carYellow, carRed}, e_car);
    check("walk", {walkTv, walkNN, walkNS}, e_walk);
    check("dontwalk", {dontWalkTv, dontWalkNN, dontWalkNS}, e_dw);
    check("resetx", {resetTv, resetNN, resetNS}, e_rst);

    flags = (flags & ~pend_clear) | req;
    {walkFlagTv, walkFlagNN, walkFlagNS} = flags;
    reset = rst_in;
    pend_clear = e_rst;

    if (rst_in) begin
      m_green  = 1'b1;
      m_g      = 0;
      m_served = 3'b000;
    end else if (m_green) begin
      if (m_g >= GMIN - 1 && |flags) begin
        m_green = 1'b0;
        m_k     = 0;
      end else m_g++;
    end else begin
      if (m_k == Y + A - 1) m_served = flags;
      m_k++;
      if (m_k == TOTAL) begin
        m_green = 1'b1;
        m_g     = 0;
      end
    end
  endtask

  function automatic bit model_in(input int which);
    case (which)
      0:       return m_green;
      1:       return !m_green && m_k < Y;
      default: return !m_green && m_k >= Y + A && m_k < Y + A + W;
    endcase
  endfunction

  // which: 0 = green, 1 = yellow, 2 = walk
  task automatic run_until(input int which);
    int n;
    n = 0;
    while (!model_in(which) && n < 200) begin
      step(1'b0, 3'b000);
      n++;
    end
    if (!model_in(which)) begin
      n_cmp++;
      n_fail++;
      $error("FAIL run_until cycle %0d: target %0d not reached within 200 cycles", cycle, which);
    end
  endtask

  initial begin
    reset = 1'b1;
    flags = 3'b000;
    pend_clear = 3'b000;
    {walkFlagTv, walkFlagNN, walkFlagNS} = 3'b000;
    repeat (2) @(posedge clk);
    m_green  = 1'b1;
    m_g      = 0;
    m_k      = 0;
    m_served = 3'b000;

    // Idle: no requests for 30 cycles.
    repeat (30) step(1'b0, 3'b000);

    // Tv pending from reset release: one full phase.
    step(1'b1, 3'b100);
    repeat (20) step(1'b0, 3'b000);

    // Tv pending, NN rising during yellow: both served together.
    step(1'b1, 3'b000);
    step(1'b0, 3'b100);
    run_until(1);
    step(1'b0, 3'b010);
    run_until(0);
    repeat (8) step(1'b0, 3'b000);

    // NS rising during walk: deferred to the following phase.
    step(1'b0, 3'b100);
    run_until(2);
    step(1'b0, 3'b001);
    repeat (30) step(1'b0, 3'b000);

    // Reset pulse during walk aborts the phase.
    step(1'b0, 3'b100);
    run_until(2);
    step(1'b0, 3'b000);
    step(1'b1, 3'b000);
    repeat (25) step(1'b0, 3'b000);

    // Request rising at green timer 1.
    step(1'b1, 3'b000);
    step(1'b0, 3'b000);
    step(1'b0, 3'b100);
    repeat (20) step(1'b0, 3'b000);

    // Random requests with occasional reset.
    repeat (800) begin
      logic [2:0] r;
      r[2] = ($urandom_range(0, 7) == 0);
      r[1] = ($urandom_range(0, 7) == 0);
      r[0] = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 99) == 0, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
